// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS memory port arbiter.
// Optional feature: MEM_ARB_RR_EN selects round-robin grant.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF, LS and memory handshakes around the arbiter.
// slave = arbiter view, master = surrounding pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              i_if_req_valid;
  logic              o_if_req_ready;
  logic [ADDR_W-1:0] i_if_req_addr;
  logic              o_if_rsp_valid;
  logic [DATA_W-1:0] o_if_rsp_data;

  logic              i_ls_req_valid;
  logic              o_ls_req_ready;
  logic [ADDR_W-1:0] i_ls_req_addr;
  logic [STRB_W-1:0] i_ls_req_wstrb;
  logic [DATA_W-1:0] i_ls_req_wdata;
  logic              o_ls_rsp_valid;
  logic [DATA_W-1:0] o_ls_rsp_data;

  logic              o_mem_req_valid;
  logic              i_mem_req_ready;
  logic [ADDR_W-1:0] o_mem_req_addr;
  logic [STRB_W-1:0] o_mem_req_wstrb;
  logic [DATA_W-1:0] o_mem_req_wdata;
  logic              i_mem_rsp_valid;
  logic [DATA_W-1:0] i_mem_rsp_data;

  modport slave (
    input  i_if_req_valid, i_if_req_addr,
    output o_if_req_ready, o_if_rsp_valid, o_if_rsp_data,
    input  i_ls_req_valid, i_ls_req_addr,
    input  i_ls_req_wstrb, i_ls_req_wdata,
    output o_ls_req_ready, o_ls_rsp_valid, o_ls_rsp_data,
    output o_mem_req_valid, o_mem_req_addr,
    output o_mem_req_wstrb, o_mem_req_wdata,
    input  i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data
  );

  modport master (
    output i_if_req_valid, i_if_req_addr,
    input  o_if_req_ready, o_if_rsp_valid, o_if_rsp_data,
    output i_ls_req_valid, i_ls_req_addr,
    output i_ls_req_wstrb, i_ls_req_wdata,
    input  o_ls_req_ready, o_ls_rsp_valid, o_ls_rsp_data,
    input  o_mem_req_valid, o_mem_req_addr,
    input  o_mem_req_wstrb, o_mem_req_wdata,
    output i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Grant decision between IF and LS.
// MEM_ARB_RR_EN: round-robin; otherwise LS priority with IF starvation guard.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic if_valid,
  input  logic ls_valid,
  input  logic accept,
  output logic gnt_if,
  output logic gnt_ls
);

`ifdef MEM_ARB_RR_EN

  arb_owner_e last_q, last_d;

  // On a tie the side that did not win last time goes first.
  always_comb begin
    gnt_ls = ls_valid && (!if_valid || last_q == OWN_IF);
    gnt_if = if_valid && !gnt_ls;
    last_d = last_q;
    if (accept) begin
      last_d = gnt_ls ? OWN_LS : OWN_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_q <= OWN_IF;
    end else begin
      last_q <= last_d;
    end
  end

`else

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             force_if;

  always_comb begin
    force_if = (cnt_q == LIMIT);
    gnt_ls   = ls_valid && !(if_valid && force_if);
    gnt_if   = if_valid && !gnt_ls;
    cnt_d    = cnt_q;
    if (accept) begin
      if (gnt_if) begin
        cnt_d = '0;
      end else if (if_valid && !force_if) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store.
// One transaction in flight; MEM_ARB_RR_EN selects round-robin grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rstn,
  mem_port_arbiter_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mvld_q, mvld_d;
  logic              if_rsp_q, if_rsp_d;
  logic              ls_rsp_q, ls_rsp_d;

  logic idle;
  logic accept;
  logic gnt_if;
  logic gnt_ls;

  // Readies stay low while reset is held.
  assign idle   = rstn && (state_q == IDLE);
  assign accept = idle && (gnt_if || gnt_ls);

  assign bus.o_if_req_ready = idle && gnt_if;
  assign bus.o_ls_req_ready = idle && gnt_ls;

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk     (clk),
    .rstn    (rstn),
    .if_valid(bus.i_if_req_valid),
    .ls_valid(bus.i_ls_req_valid),
    .accept  (accept),
    .gnt_if  (gnt_if),
    .gnt_ls  (gnt_ls)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mvld_d   = mvld_q;
    if_rsp_d = 1'b0;
    ls_rsp_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mvld_d  = 1'b1;
          state_d = REQ;
          if (gnt_ls) begin
            owner_d = OWN_LS;
            addr_d  = bus.i_ls_req_addr;
            wstrb_d = bus.i_ls_req_wstrb;
            wdata_d = bus.i_ls_req_wdata;
          end else begin
            owner_d = OWN_IF;
            addr_d  = bus.i_if_req_addr;
            wstrb_d = '0;
            wdata_d = '0;
          end
        end
      end
      REQ: begin
        if (bus.i_mem_req_ready) begin
          mvld_d  = 1'b0;
          state_d = RSP;
        end
      end
      RSP: begin
        if (bus.i_mem_rsp_valid) begin
          rdata_d  = bus.i_mem_rsp_data;
          if_rsp_d = (owner_q == OWN_IF);
          ls_rsp_d = (owner_q == OWN_LS);
          state_d  = IDLE;
        end
      end
      default: begin
        mvld_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      addr_q   <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mvld_q   <= 1'b0;
      if_rsp_q <= 1'b0;
      ls_rsp_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mvld_q   <= mvld_d;
      if_rsp_q <= if_rsp_d;
      ls_rsp_q <= ls_rsp_d;
    end
  end

  assign bus.o_mem_req_valid = mvld_q;
  assign bus.o_mem_req_addr  = addr_q;
  assign bus.o_mem_req_wstrb = wstrb_q;
  assign bus.o_mem_req_wdata = wdata_q;
  assign bus.o_if_rsp_valid  = if_rsp_q;
  assign bus.o_if_rsp_data   = rdata_q;
  assign bus.o_ls_rsp_valid  = ls_rsp_q;
  assign bus.o_ls_rsp_data   = rdata_q;

endmodule
